// File: rtl/vsync_phase_detector_pkg.sv
// Shared lock-state encodings, default parameters and a counter-width helper
// for the vsync phase detector.
package vsync_phase_detector_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'b00,
        S_ACQ  = 2'b01,
        S_LOCK = 2'b10
    } state_t;

    localparam int unsigned WIDTH_ERR_DEF = 22;
    localparam int unsigned LOCK_CNT_DEF  = 8;
    localparam int unsigned MISS_CNT_DEF  = 4;
    localparam int unsigned TIMEOUT_DEF   = 2475000;

    // Bits needed to hold values 0..n inclusive.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vsync_phase_detector_sync_edge.sv
// Optional 2-FF synchronizer followed by a one-register rising-edge detector.
// With SYNC=0 the input is already clock-synchronous and only the edge register remains.
module vsync_phase_detector_sync_edge #(
    parameter bit SYNC = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_c
);

    logic level;
    logic prev;

    generate
        if (SYNC) begin : g_sync
            logic [1:0] meta;

            always_ff @(posedge clk) begin
                if (rst) begin
                    meta <= '0;
                end else begin
                    meta <= {meta[0], din};
                end
            end

            assign level = meta[1];
        end else begin : g_bypass
            assign level = din;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise_c = level & ~prev;

endmodule

// File: rtl/vsync_phase_detector.sv
// Phase detector for the vsync fractional-divider loop: measures the Fref period,
// turns each vsync edge into a signed phase error and tracks window lock.
module vsync_phase_detector
    import vsync_phase_detector_pkg::*;
#(
    parameter int unsigned WIDTH_ERR = WIDTH_ERR_DEF,
    parameter int unsigned LOCK_CNT  = LOCK_CNT_DEF,
    parameter int unsigned MISS_CNT  = MISS_CNT_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                        sp_clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        fref,
    input  logic                        vsync_in,
    input  logic [9:0]                  win_width,
    output logic signed [WIDTH_ERR-1:0] err,
    output logic                        err_valid,
    output logic [WIDTH_ERR-2:0]        period,
    output logic                        venable,
    output logic                        pd_error
);

    localparam int unsigned PW = WIDTH_ERR - 1;
    localparam int unsigned TW = cnt_bits(TIMEOUT);
    localparam int unsigned HW = cnt_bits(LOCK_CNT);
    localparam int unsigned MW = cnt_bits(MISS_CNT);
    localparam logic [PW-1:0] PH_MAX = '1;

    logic                 fr_rise;
    logic                 vs_rise;
    logic [PW-1:0]        ph;
    logic [PW-1:0]        e;
    logic                 have_prev;
    logic                 per_ok;
    logic [TW-1:0]        timer;
    logic                 timeout_c;
    logic [WIDTH_ERR-1:0] e_ext;
    logic [WIDTH_ERR-1:0] per_ext;
    logic [WIDTH_ERR-1:0] err_c;
    logic [WIDTH_ERR-1:0] abs_c;
    logic                 sample_c;
    logic                 hit_c;
    logic                 miss_c;
    state_t               state;
    logic [HW-1:0]        hit_cnt;
    logic [MW-1:0]        miss_cnt;

    vsync_phase_detector_sync_edge #(.SYNC(1'b1)) u_vs_edge (
        .clk    (sp_clk),
        .rst    (rst),
        .din    (vsync_in),
        .rise_c (vs_rise)
    );

    vsync_phase_detector_sync_edge #(.SYNC(1'b0)) u_fr_edge (
        .clk    (sp_clk),
        .rst    (rst),
        .din    (fref),
        .rise_c (fr_rise)
    );

    // Phase counter and period capture; a saturated phase means Fref has stopped.
    always_ff @(posedge sp_clk) begin
        if (rst) begin
            ph        <= '0;
            period    <= '0;
            have_prev <= 1'b0;
            per_ok    <= 1'b0;
        end else if (fr_rise) begin
            ph        <= PW'(1);
            have_prev <= 1'b1;
            if (have_prev && (ph != PH_MAX)) begin
                period <= ph;
                per_ok <= 1'b1;
            end
        end else if (ph == PH_MAX) begin
            per_ok    <= 1'b0;
            have_prev <= 1'b0;
        end else begin
            ph <= ph + PW'(1);
        end
    end

    // Offsets at or past half a period wrap to a negative error (vsync leads the next edge).
    assign e       = fr_rise ? '0 : ph;
    assign e_ext   = {1'b0, e};
    assign per_ext = {1'b0, period};
    assign err_c   = (e < (period >> 1)) ? e_ext : (e_ext - per_ext);
    assign abs_c   = err_c[WIDTH_ERR-1] ? -err_c : err_c;

    assign sample_c = vs_rise & per_ok & enable;
    assign hit_c    = (abs_c <= WIDTH_ERR'(win_width));
    assign miss_c   = (sample_c & ~hit_c) | timeout_c;

    // Vsync watchdog, only armed while samples are possible.
    assign timeout_c = enable && per_ok && !vs_rise && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge sp_clk) begin
        if (rst) begin
            timer <= '0;
        end else if (!enable || !per_ok || vs_rise || timeout_c) begin
            timer <= '0;
        end else if (timer != TW'(TIMEOUT - 1)) begin
            timer <= timer + TW'(1);
        end
    end

    // Error output and lock state machine share one update cycle.
    always_ff @(posedge sp_clk) begin
        if (rst) begin
            state     <= S_INIT;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            venable   <= 1'b0;
            err       <= '0;
            err_valid <= 1'b0;
            pd_error  <= 1'b0;
        end else begin
            err_valid <= sample_c;
            pd_error  <= miss_c;
            if (sample_c) begin
                err <= $signed(err_c);
            end

            if (!enable || !per_ok) begin
                state    <= S_INIT;
                hit_cnt  <= '0;
                miss_cnt <= '0;
                venable  <= 1'b0;
            end else begin
                case (state)
                    S_INIT: begin
                        state    <= S_ACQ;
                        hit_cnt  <= '0;
                        miss_cnt <= '0;
                        venable  <= 1'b0;
                    end
                    S_ACQ: begin
                        if (miss_c) begin
                            hit_cnt <= '0;
                        end else if (sample_c) begin
                            if (hit_cnt >= HW'(LOCK_CNT - 1)) begin
                                state    <= S_LOCK;
                                venable  <= 1'b1;
                                hit_cnt  <= '0;
                                miss_cnt <= '0;
                            end else begin
                                hit_cnt <= hit_cnt + HW'(1);
                            end
                        end
                    end
                    S_LOCK: begin
                        if (miss_c) begin
                            if (miss_cnt >= MW'(MISS_CNT - 1)) begin
                                state    <= S_ACQ;
                                venable  <= 1'b0;
                                hit_cnt  <= '0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MW'(1);
                            end
                        end else if (sample_c) begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= S_INIT;
                        hit_cnt  <= '0;
                        miss_cnt <= '0;
                        venable  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
